// File: rtl/rv32i_instr_encoder_if.sv
// Handshake bundle for the RV32I instruction encoder: descriptor input
// channel, encoded word output channel, restart and illegal-descriptor status.
interface rv32i_instr_encoder_if #(
    parameter int ADDR_W = 10
);
    logic              restart;
    logic              in_valid;
    logic              in_ready;
    logic              in_itype;
    logic [3:0]        in_alu_op;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [11:0]       in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic              err_illegal;
    logic [7:0]        illegal_cnt;

    // Encoder side
    modport slave (
        input  restart, in_valid, in_itype, in_alu_op, in_rd, in_rs1, in_rs2,
               in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_addr, err_illegal, illegal_cnt
    );

    // Producer / consumer side
    modport master (
        output restart, in_valid, in_itype, in_alu_op, in_rd, in_rs1, in_rs2,
               in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_addr, err_illegal, illegal_cnt
    );
endinterface

// File: rtl/rv32i_instr_encoder.sv
// Streaming RV32I encoder: packs ALU-op descriptors into R-type / I-type ALU
// words, queues them in a small FIFO and emits them with a word address that
// advances by 4 per pop. Illegal descriptors are accepted but dropped.
module rv32i_instr_encoder #(
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input logic                  clk,
    input logic                  rst_n,
    rv32i_instr_encoder_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    logic [DEPTH-1:0][31:0] mem_q, mem_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]            cnt_q, cnt_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic                   err_q, err_d;
    logic [7:0]             ill_cnt_q, ill_cnt_d;

    logic [31:0] word;
    logic        illegal;
    logic [2:0]  funct3;
    logic        is_shift;
    logic        alt;        // funct7 = 0100000 (sub / sra)
    logic [6:0]  funct7;
    logic        full, empty, accept, push, pop;

    // Combinational encode of the descriptor currently on the input
    always_comb begin
        funct3   = 3'b000;
        is_shift = 1'b0;
        alt      = 1'b0;
        illegal  = 1'b0;
        case (bus.in_alu_op)
            4'b0000: funct3 = 3'b000;
            4'b0001: begin funct3 = 3'b000; alt = 1'b1; end
            4'b0010: begin funct3 = 3'b001; is_shift = 1'b1; end
            4'b0011: funct3 = 3'b010;
            4'b0100: funct3 = 3'b011;
            4'b0101: funct3 = 3'b100;
            4'b0110: begin funct3 = 3'b101; is_shift = 1'b1; end
            4'b0111: begin funct3 = 3'b101; is_shift = 1'b1; alt = 1'b1; end
            4'b1000: funct3 = 3'b110;
            4'b1001: funct3 = 3'b111;
            default: illegal = 1'b1;
        endcase
        // There is no subtract-immediate in RV32I
        if (bus.in_itype && bus.in_alu_op == 4'b0001)
            illegal = 1'b1;
        funct7 = alt ? 7'b0100000 : 7'b0000000;
        if (!bus.in_itype)
            word = {funct7, bus.in_rs2, bus.in_rs1, funct3, bus.in_rd, 7'b0110011};
        else if (is_shift)
            word = {funct7, bus.in_imm[4:0], bus.in_rs1, funct3, bus.in_rd, 7'b0010011};
        else
            word = {bus.in_imm, bus.in_rs1, funct3, bus.in_rd, 7'b0010011};
    end

    assign full   = (cnt_q == (PW+1)'(DEPTH));
    assign empty  = (cnt_q == '0);
    assign accept = bus.in_valid && bus.in_ready;
    assign push   = accept && !illegal;
    assign pop    = !empty && bus.out_ready;

    assign bus.in_ready    = !full && !bus.restart;
    assign bus.out_valid   = !empty;
    assign bus.out_instr   = mem_q[rd_ptr_q];
    assign bus.out_addr    = addr_q;
    assign bus.err_illegal = err_q;
    assign bus.illegal_cnt = ill_cnt_q;

    // Next-state for FIFO, address counter and illegal-descriptor status
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        err_d     = accept && illegal;
        ill_cnt_d = ill_cnt_q;
        if (accept && illegal && ill_cnt_q != 8'hFF)
            ill_cnt_d = ill_cnt_q + 8'd1;
        if (bus.restart) begin
            // Flush drops any same-cycle pop; accept is already blocked
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            addr_d   = BASE;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = word;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
                addr_d   = addr_q + ADDR_W'(4);
            end
            cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            addr_q    <= BASE;
            err_q     <= 1'b0;
            ill_cnt_q <= '0;
        end else begin
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            err_q     <= err_d;
            ill_cnt_q <= ill_cnt_d;
        end
    end
endmodule
